// File: rtl/buffer_reader.sv
// Read-side consumer of the shared data buffer: pops one word, converts it to
// five BCD digits with a sequential double-dabble and shows it for a number of ticks.
module buffer_reader #(
    parameter int DWELL_TICKS = 1,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic [15:0] data_2,
    output logic [19:0] bcd,
    output logic        data_2_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        CONV,
        SHOW
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);

    state_t            state;
    state_t            state_next;
    logic [35:0]       shift_q;
    logic [35:0]       shift_adj;
    logic [35:0]       shift_conv;
    logic [15:0]       word_q;
    logic [3:0]        iter_q;
    logic [CNT_W-1:0]  dwell_q;
    logic              conv_last;
    logic              dwell_done;

    assign conv_last  = (iter_q == 4'd15);
    assign dwell_done = tick && (dwell_q == DWELL_LAST);

    // Double-dabble step: correct every BCD nibble that would overflow on the shift.
    always_comb begin
        shift_adj = shift_q;
        for (int k = 0; k < 5; k++) begin
            if (shift_q[16 + 4*k +: 4] >= 4'd5) begin
                shift_adj[16 + 4*k +: 4] = shift_q[16 + 4*k +: 4] + 4'd3;
            end
        end
    end

    assign shift_conv = shift_adj << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        fifo_rd_en   = 1'b0;
        data_2_valid = 1'b0;
        busy         = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (!fifo_empty) begin
                    state_next = RD;
                end
            end
            RD: begin
                fifo_rd_en = 1'b1;
                state_next = CAP;
            end
            CAP: begin
                state_next = CONV;
            end
            CONV: begin
                if (conv_last) begin
                    state_next = SHOW;
                end
            end
            SHOW: begin
                data_2_valid = 1'b1;
                // Going straight back to RD avoids an IDLE bubble between words.
                if (dwell_done) begin
                    state_next = fifo_empty ? IDLE : RD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The last conversion step also publishes the result, so bcd and data_2
    // always change together on the SHOW entry edge and hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            word_q  <= '0;
            iter_q  <= '0;
            dwell_q <= '0;
            data_2  <= '0;
            bcd     <= '0;
        end else begin
            unique case (state)
                CAP: begin
                    shift_q <= {20'd0, fifo_dout};
                    word_q  <= fifo_dout;
                    iter_q  <= '0;
                end
                CONV: begin
                    shift_q <= shift_conv;
                    iter_q  <= iter_q + 4'd1;
                    if (conv_last) begin
                        bcd     <= shift_conv[35:16];
                        data_2  <= word_q;
                        dwell_q <= '0;
                    end
                end
                SHOW: begin
                    if (tick) begin
                        dwell_q <= dwell_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_reader.sv
// Self-checking bench for buffer_reader: BCD vector table, directed multi-cycle
// corner cases and randomized traffic against a per-word timeline model.
module tb_buffer_reader;

    localparam int DWELL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_rd_en;
    logic [15:0] data_2;
    logic [19:0] bcd;
    logic        data_2_valid;
    logic        busy;

    always #5 clk = ~clk;

    buffer_reader #(.DWELL_TICKS(DWELL), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .data_2       (data_2),
        .bcd          (bcd),
        .data_2_valid (data_2_valid),
        .busy         (busy)
    );

    typedef struct {
        logic [15:0] word;
        logic [19:0] exp_bcd;
    } vec_t;

    vec_t vecs[10];

    int nchecks = 0;
    int nerrs   = 0;
    int rd_count;

    logic [15:0] fq[$];
    logic [15:0] mq[$];

    // Reference model: a word is popped at age 0, shown from age 18 on,
    // and leaves after DWELL ticks counted from the first shown cycle.
    bit          m_active;
    int          m_age;
    int          m_ticks;
    logic [15:0] m_word;
    logic [15:0] m_d2;
    logic [19:0] m_bcd;

    function automatic logic [19:0] to_bcd(input int v);
        return {4'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [38:0] dut_vec();
        return {fifo_rd_en, data_2_valid, busy, data_2, bcd};
    endfunction

    function automatic logic [38:0] model_vec();
        logic rd_e;
        logic val_e;
        rd_e  = m_active && (m_age == 0);
        val_e = m_active && (m_age >= 18);
        return {rd_e, val_e, m_active, m_d2, m_bcd};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nchecks++;
        if (act !== req) begin
            nerrs++;
            $display("[TB] FAIL %s: actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_ticks  = 0;
        m_word   = '0;
        m_d2     = '0;
        m_bcd    = '0;
    endtask

    task automatic model_pop();
        if (mq.size() > 0) begin
            m_word = mq.pop_front();
        end else begin
            m_word = '0;
        end
    endtask

    task automatic model_step();
        if (!m_active) begin
            if (!fifo_empty) begin
                m_active = 1'b1;
                m_age    = 0;
                model_pop();
            end
        end else if (m_age < 18) begin
            m_age++;
            if (m_age == 18) begin
                m_d2    = m_word;
                m_bcd   = to_bcd(int'(m_word));
                m_ticks = 0;
            end
        end else begin
            if (tick) m_ticks++;
            if (m_ticks == DWELL) begin
                if (!fifo_empty) begin
                    m_age = 0;
                    model_pop();
                end else begin
                    m_active = 1'b0;
                end
            end
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        fq.push_back(w);
        mq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: apply tick, advance the model, emulate the buffer's registered
    // read data, then compare every output against the model.
    task automatic applyStimulus(input logic t);
        logic rd_seen;
        tick = t;
        if (rst) model_reset();
        else model_step();
        rd_seen = fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd_seen) begin
            check("pop_nonempty", 64'(fq.size() > 0), 64'd1);
            if (fq.size() > 0) fifo_dout = fq.pop_front();
        end
        fifo_empty = (fq.size() == 0);
        check("cycle", 64'(dut_vec()), 64'(model_vec()));
        if (fifo_rd_en) rd_count++;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((busy || fq.size() > 0) && n < bound) begin
            applyStimulus(1'b1);
            n++;
        end
        check("drain_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int   n;
        int   lat;
        bit   got;
        logic prev_valid;
        int   nshows;
        int   ndrops;
        logic [19:0] shown[2];

        vecs[0] = '{16'd0,     20'h00000};
        vecs[1] = '{16'd1,     20'h00001};
        vecs[2] = '{16'd9,     20'h00009};
        vecs[3] = '{16'd10,    20'h00010};
        vecs[4] = '{16'd99,    20'h00099};
        vecs[5] = '{16'd1597,  20'h01597};
        vecs[6] = '{16'd4660,  20'h04660};
        vecs[7] = '{16'd9999,  20'h09999};
        vecs[8] = '{16'd10000, 20'h10000};
        vecs[9] = '{16'd65535, 20'h65535};

        tick       = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        rst        = 1'b0;
        rd_count   = 0;
        model_reset();

        #2 rst = 1'b1;
        #1;
        check("reset_state", 64'(dut_vec()), 64'd0);
        repeat (3) applyStimulus(1'b0);
        rst = 1'b0;

        // Empty buffer for 100 clocks: nothing may be popped.
        rd_count = 0;
        for (int i = 0; i < 100; i++) applyStimulus(1'($urandom_range(0, 1)));
        check("idle_no_rd", 64'(rd_count), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // Vector table: conversion result and RD-to-valid latency per word.
        for (int i = 0; i < 10; i++) begin
            push_word(vecs[i].word);
            n = 0; got = 0; lat = -1;
            while (!got && n < 60) begin
                applyStimulus(1'b1);
                n++;
                if (fifo_rd_en) lat = 0;
                else if (lat >= 0) lat++;
                if (data_2_valid) got = 1;
            end
            check("tbl_valid_seen", 64'(got), 64'd1);
            check("tbl_latency", 64'(lat), 64'd18);
            check("tbl_data_2", 64'(data_2), 64'(vecs[i].word));
            check("tbl_bcd", 64'(bcd), 64'(vecs[i].exp_bcd));
            drain(20);
        end

        // Back-to-back words with a tick every 10 clocks.
        push_word(16'h0000);
        push_word(16'h063D);
        prev_valid = data_2_valid;
        nshows = 0; ndrops = 0;
        shown[0] = 20'hFFFFF; shown[1] = 20'hFFFFF;
        for (int c = 0; c < 300 && ndrops < 2; c++) begin
            applyStimulus(1'((c % 10) == 9));
            if (data_2_valid && !prev_valid) begin
                if (nshows < 2) shown[nshows] = bcd;
                nshows++;
            end
            if (!data_2_valid && prev_valid) begin
                check("b2b_rd_on_drop", 64'(fifo_rd_en), 64'(ndrops == 0));
                ndrops++;
            end
            prev_valid = data_2_valid;
        end
        check("b2b_shows", 64'(nshows), 64'd2);
        check("b2b_first_bcd", 64'(shown[0]), 64'h00000);
        check("b2b_second_bcd", 64'(shown[1]), 64'h01597);
        drain(20);

        // Tick in every SHOW cycle from the first: SHOW lasts exactly DWELL clocks.
        push_word(16'd42);
        n = 0;
        while (!data_2_valid && n < 40) begin
            applyStimulus(1'b0);
            n++;
        end
        check("first_show_seen", 64'(data_2_valid), 64'd1);
        n = 0;
        while (data_2_valid && n < 10) begin
            applyStimulus(1'b1);
            n++;
        end
        check("show_len", 64'(n), 64'(DWELL));
        drain(20);

        // Async reset during the 8th CONV cycle of 0x1234.
        push_word(16'h1234);
        n = 0;
        while (!fifo_rd_en && n < 10) begin
            applyStimulus(1'b0);
            n++;
        end
        check("rst_rd_seen", 64'(fifo_rd_en), 64'd1);
        repeat (9) applyStimulus(1'b0);
        check("rst_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 64'(dut_vec()), 64'd0);
        model_reset();
        repeat (2) applyStimulus(1'b0);
        rst = 1'b0;
        rd_count = 0;
        repeat (30) applyStimulus(1'b1);
        check("rst_no_rd", 64'(rd_count), 64'd0);

        // Ticks while idle and converting must not count toward the dwell.
        repeat (5) applyStimulus(1'b1);
        push_word(16'd9999);
        n = 0;
        while (!data_2_valid && n < 40) begin
            applyStimulus(1'b1);
            n++;
        end
        check("dwell_bcd", 64'(bcd), 64'h09999);
        repeat (5) applyStimulus(1'b0);
        check("dwell_hold", 64'(data_2_valid), 64'd1);
        drain(20);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0 && fq.size() < 4) begin
                case ($urandom_range(0, 7))
                    0:       push_word(16'h0000);
                    1:       push_word(16'hFFFF);
                    default: push_word(16'($urandom));
                endcase
            end
            applyStimulus(1'($urandom_range(0, 3) == 0));
        end
        drain(400);

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

endmodule

// File: doc/buffer_reader.md
Name: buffer_reader

Overview:
- Read-side consumer of the shared data buffer, paired with the Fibonacci and Timer producers on the write side.
- Pops one 16-bit word at a time from the buffer and converts it to 5-digit BCD with a sequential double-dabble.
- Presents the word to the display path for a programmable number of slow-time-base ticks.
- Drives data_2_valid, which the top-level FSM uses (with buffer empty) to leave the buffer-drain state.

Parameters:
- DWELL_TICKS, 1, number of tick pulses each word stays in SHOW (valid range 1..255).
- CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > DWELL_TICKS.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-clk-wide enable pulse from the slow time base; the block stays synchronous to clk.
- fifo_empty  in  1  buffer empty flag.
- fifo_dout  in  16  buffer read data, valid exactly 1 clk after a cycle with fifo_rd_en=1.
- fifo_rd_en  out  1  pop request, one clk wide.
- data_2  out  16  binary value of the word currently shown.
- bcd  out  20  five BCD digits of data_2; [19:16] is the most significant digit.
- data_2_valid  out  1  high while a word is being shown.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async): state=IDLE.
  - All outputs 0: fifo_rd_en, data_2, bcd, data_2_valid, busy.
  - Internal shift register and dwell counter cleared.
  - Reset asserted mid-operation aborts immediately. The popped word is discarded and no further rd_en is issued until reset is released.
- FSM states: IDLE, RD, CAP, CONV, SHOW. Outputs are Moore-decoded from registered state.
- IDLE:
  - fifo_empty=0 -> RD next clk.
  - tick is ignored.
- RD:
  - fifo_rd_en=1 for exactly this cycle.
  - Always -> CAP.
- CAP:
  - Capture fifo_dout into a 36-bit shift register: binary in [15:0], zeros in [35:16].
  - Clear iteration counter. -> CONV.
- CONV: exactly 16 cycles. Each cycle:
  - Any 4-bit BCD nibble in [35:16] that is >=5 gets +3.
  - Then shift the whole register left by 1.
  - After the 16th cycle -> SHOW.
- SHOW:
  - On the entry edge, register bcd<=shift[35:16] and data_2<=captured word. Both update together, never separately.
  - data_2_valid=1 throughout SHOW. Dwell counter is cleared on entry.
  - Each cycle with tick=1 increments the counter, including the first SHOW cycle.
  - When the count reaches DWELL_TICKS, on that same cycle: -> RD if fifo_empty=0, else -> IDLE.
- Latency: valid rises exactly 18 clk after the RD cycle (RD=cycle 0, CAP=1, CONV=2..17, SHOW from 18).
- Back-to-back words: SHOW goes directly to RD, with no IDLE bubble. data_2_valid drops for 18 clk between words.
- data_2 and bcd hold their last values after SHOW until the next SHOW entry. Only data_2_valid drops.
- Exactly one pop per displayed word.
  - fifo_rd_en is never asserted when fifo_empty was 1 in the deciding cycle.
  - Never asserted outside RD.
- fifo_empty rising while in CAP/CONV/SHOW has no effect; the word in flight completes.
- Arithmetic: 0..65535 maps to 00000..65535. No overflow is possible in 20 bits.
- Drain completion, as seen by the top level: fifo_empty=1 and data_2_valid=0. This holds only in IDLE, or transiently in RD/CAP/CONV when the last word was popped.

Test Plan:
- Reset then fifo_empty=1 for 100 clk -> fifo_rd_en stays 0, busy=0, all outputs 0.
- One word 0xFFFF, tick every 10 clk, DWELL_TICKS=1 -> single rd_en pulse; 18 clk later data_2_valid=1, data_2=0xFFFF, bcd=20'h65535; valid drops after the first tick; state returns to IDLE.
- Words 0x0000 then 1597 (0x063D), fifo not empty between them, DWELL_TICKS=3 -> first bcd=20'h00000 held for 3 ticks; rd_en fires in the same cycle valid drops; second bcd=20'h01597.
- Tick asserted in the first SHOW cycle with DWELL_TICKS=1 -> SHOW lasts exactly 1 clk.
- Async rst asserted during the 8th CONV cycle of word 0x1234 -> all outputs 0 immediately; after release with fifo_empty=1, no rd_en is issued.
- Tick pulses while IDLE/CONV, then a word 9999 -> dwell count starts at SHOW entry only; bcd=20'h09999.
